// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the multiply/divide unit.
//   op_t    : operation codes carried on the 4-bit op port
//   state_t : control FSM states of mdu_iter
//   is_div / is_signed_op / is_arith : op classification helpers
package mdu_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MTHI  = 4'd8,
        MTLO  = 4'd9
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_div(input op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
    endfunction

    // Ops that occupy the unit for a latency window and end with done.
    function automatic logic is_arith(input op_t op);
        logic r;
        case (op)
            MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: issue/result bundle between the Execute stage and mdu_iter.
//   start, op, a, b, flush : request side (driven by the pipeline)
//   busy, done, hi, lo     : status and HI/LO register values (driven by the unit)
// master = pipeline side, slave = multiply/divide unit side.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider, one quotient bit per step.
//   start     : latch operands (only when not running)
//   flush     : abandon the division in progress
//   is_signed : signed division (truncate toward zero, remainder takes dividend sign)
//   dividend, divisor : operands sampled with start
//   valid     : high in the last cycle of the DIV_LAT window; quotient/remainder
//               are final during that cycle
// The WIDTH steps are spread over exactly DIV_LAT cycles: several steps per
// cycle when DIV_LAT < WIDTH, idle padding cycles at the front otherwise.
// The last batch of steps is combinational so DIV_LAT=1 works.
module mdu_divider #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned STEPS      = (WIDTH + DIV_LAT - 1) / DIV_LAT;
    localparam int unsigned ACTIVE_CYC = (WIDTH + STEPS - 1) / STEPS;
    localparam int unsigned CYW        = $clog2(DIV_LAT + 1);
    localparam int unsigned BW         = $clog2(WIDTH + 1);

    logic             active;
    logic [CYW-1:0]   cyc;
    logic [WIDTH-1:0] rem, quo, dsr;
    logic [BW-1:0]    bits;
    logic             neg_q, neg_r, dz;

    logic [WIDTH-1:0] nrem, nquo;
    logic [BW-1:0]    nbits;
    logic [WIDTH:0]   trial;

    logic             dvd_neg, dsr_neg;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dsr_neg = is_signed & divisor[WIDTH-1];

    // One cycle's worth of restoring steps; quo shifts the dividend out
    // at the top while quotient bits enter at the bottom.
    always_comb begin
        nrem  = rem;
        nquo  = quo;
        nbits = bits;
        trial = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            if (nbits != '0) begin
                trial = {nrem, nquo[WIDTH-1]};
                nquo  = {nquo[WIDTH-2:0], 1'b0};
                if (trial >= {1'b0, dsr}) begin
                    nrem    = trial[WIDTH-1:0] - dsr;
                    nquo[0] = 1'b1;
                end else begin
                    nrem = trial[WIDTH-1:0];
                end
                nbits = nbits - BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cyc    <= '0;
            rem    <= '0;
            quo    <= '0;
            dsr    <= '0;
            bits   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cyc    <= CYW'(DIV_LAT);
            rem    <= '0;
            quo    <= dvd_neg ? -dividend : dividend;
            dsr    <= dsr_neg ? -divisor : divisor;
            bits   <= BW'(WIDTH);
            neg_q  <= dvd_neg ^ dsr_neg;
            neg_r  <= dvd_neg;
            dz     <= (divisor == '0);
        end else if (active) begin
            if (flush) begin
                active <= 1'b0;
            end else begin
                if (cyc <= CYW'(ACTIVE_CYC)) begin
                    rem  <= nrem;
                    quo  <= nquo;
                    bits <= nbits;
                end
                cyc <= cyc - CYW'(1);
                if (cyc == CYW'(1))
                    active <= 1'b0;
            end
        end
    end

    assign valid = active && (cyc == CYW'(1));

    // Divide by zero: the unsigned magnitude quotient is all ones and the
    // remainder is |a|, which after the dividend-sign fixup is exactly a.
    // Only the quotient needs forcing. MIN/-1 needs no special case: the
    // magnitude quotient 2^(WIDTH-1) negates to itself, remainder 0.
    assign quotient  = dz ? '1 : (neg_q ? -nquo : nquo);
    assign remainder = neg_r ? -nrem : nrem;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: Execute-stage multiply/divide unit owning the HI/LO registers.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mdu_iter_if slave port
//                start/op/a/b issue an op (sampled only when idle),
//                flush cancels an in-flight op and suppresses a same-cycle start,
//                busy covers the latency window, done pulses when HI/LO take
//                an arithmetic result, hi/lo are the registers.
// Multiply and multiply-accumulate are evaluated from operands latched at
// start and written on the last cycle of MULT_LAT; division runs in mdu_divider.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    op_t              op_r;
    op_t              op_in;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    logic [2*WIDTH-1:0] ea, eb, prod, acc, result;
    logic               div_start, div_valid, finish;
    logic [WIDTH-1:0]   div_q, div_r;

    assign op_in     = op_t'(bus.op);
    assign div_start = (state == IDLE) && bus.start && !bus.flush && is_div(op_in);

    mdu_divider #(
        .WIDTH   (WIDTH),
        .DIV_LAT (DIV_LAT)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .flush     (bus.flush),
        .is_signed (op_in == DIV),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .valid     (div_valid),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Extending both operands to 2*WIDTH and truncating the product gives the
    // correct signed or unsigned product modulo 2^(2*WIDTH).
    always_comb begin
        ea     = is_signed_op(op_r) ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
        eb     = is_signed_op(op_r) ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
        prod   = ea * eb;
        acc    = {hi_q, lo_q};
        result = acc;
        case (op_r)
            MULT, MULTU: result = prod;
            MADD, MADDU: result = acc + prod;
            MSUB, MSUBU: result = acc - prod;
            DIV, DIVU:   result = {div_r, div_q};
            default:     result = acc;
        endcase
    end

    // Both the local counter and the divider are loaded with their latency on
    // the same edge, so div_valid lands on the counter's last cycle.
    assign finish = is_div(op_r) ? div_valid : (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= MULT;
            a_r    <= '0;
            b_r    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (is_arith(op_in)) begin
                            op_r   <= op_in;
                            a_r    <= bus.a;
                            b_r    <= bus.b;
                            cnt    <= is_div(op_in) ? CW'(DIV_LAT) : CW'(MULT_LAT);
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else if (op_in == MTHI) begin
                            hi_q <= bus.a;
                        end else if (op_in == MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (finish) begin
                        {hi_q, lo_q} <= result;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter.
// Two instances share clk/reset: unit 0 with default latencies (5/10) and
// unit 1 with the latency limits (MULT_LAT=1, DIV_LAT=33). Expected HI/LO
// values come from an arithmetic reference model of the op semantics.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    int ml [2] = '{5, 1};
    int dl [2] = '{10, 33};

    logic [31:0] mhi [2];
    logic [31:0] mlo [2];

    mdu_iter_if #(.WIDTH(32)) i0 ();
    mdu_iter_if #(.WIDTH(32)) i1 ();

    mdu_iter #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (i0)
    );

    mdu_iter #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(33)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (i1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference semantics, straight from the arithmetic rules.
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op_t'(op))
            MULT:  return sp;
            MULTU: return up;
            MADD:  return cur + sp;
            MADDU: return cur + up;
            MSUB:  return cur - sp;
            MSUBU: return cur - up;
            DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            MTHI:    return {a, cur[31:0]};
            MTLO:    return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic s, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic f);
        if (u == 0) begin
            i0.start = s; i0.op = op; i0.a = a; i0.b = b; i0.flush = f;
        end else begin
            i1.start = s; i1.op = op; i1.a = a; i1.b = b; i1.flush = f;
        end
    endtask

    function automatic logic [63:0] hilo(input int u);
        return (u == 0) ? {i0.hi, i0.lo} : {i1.hi, i1.lo};
    endfunction

    function automatic logic [63:0] busy_of(input int u);
        return (u == 0) ? 64'(i0.busy) : 64'(i1.busy);
    endfunction

    function automatic logic [63:0] done_of(input int u);
        return (u == 0) ? 64'(i0.done) : 64'(i1.done);
    endfunction

    function automatic logic [63:0] model(input int u);
        return {mhi[u], mlo[u]};
    endfunction

    // Called at a negedge; issues the op in this cycle and returns at the
    // negedge of the result cycle, so a following call is back-to-back.
    task automatic run_op(input int u, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        exp = ref_op(op, a, b, model(u));
        drive(u, 1'b1, op, a, b, 1'b0);
        if (is_arith(op_t'(op))) begin
            lat = is_div(op_t'(op)) ? dl[u] : ml[u];
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                drive(u, 1'b0, op, $urandom, $urandom, 1'b0);
                chk("busy_run", busy_of(u), 64'd1);
                chk("done_run", done_of(u), 64'd0);
            end
            @(negedge clk);
            chk("busy_end", busy_of(u), 64'd0);
            chk("done_end", done_of(u), 64'd1);
            chk("hilo_res", hilo(u), exp);
        end else begin
            @(negedge clk);
            drive(u, 1'b0, op, 32'd0, 32'd0, 1'b0);
            chk("busy_nop", busy_of(u), 64'd0);
            chk("done_nop", done_of(u), 64'd0);
            chk("hilo_nop", hilo(u), exp);
        end
        {mhi[u], mlo[u]} = exp;
    endtask

    initial begin
        logic [63:0] exp;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b1;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", busy_of(u), 64'd0);
            chk("rst_done", done_of(u), 64'd0);
            chk("rst_hilo", hilo(u), 64'd0);
            mhi[u] = '0;
            mlo[u] = '0;
        end
        reset = 1'b0;

        // Directed items on the default-latency unit.
        run_op(0, MULT, 32'hFFFFFFFD, 32'd7);
        chk("tp_mult", hilo(0), 64'hFFFFFFFF_FFFFFFEB);
        run_op(0, MTLO, 32'd5, 32'd0);
        run_op(0, MADDU, 32'hFFFFFFFF, 32'd2);
        chk("tp_maddu", hilo(0), 64'h00000001_00000003);
        run_op(0, DIV, 32'hFFFFFFF9, 32'd2);
        chk("tp_div", hilo(0), 64'hFFFFFFFF_FFFFFFFD);
        run_op(0, DIVU, 32'd9, 32'd0);
        chk("tp_divu0", hilo(0), 64'h00000009_FFFFFFFF);
        run_op(0, DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("tp_ovf", hilo(0), 64'h00000000_80000000);
        run_op(0, DIV, 32'hFFFFFFF0, 32'd0);
        chk("tp_div0s", hilo(0), 64'hFFFFFFF0_FFFFFFFF);
        run_op(0, MSUB, 32'd3, 32'd4);
        run_op(0, 4'd13, 32'd77, 32'd1);

        // Flush in busy cycle 4 of a divide.
        drive(0, 1'b1, DIV, 32'd1000, 32'd7, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("fl_busy", busy_of(0), 64'd1);
            drive(0, 1'b0, DIV, 32'd0, 32'd0, (i == 4));
        end
        @(negedge clk);
        drive(0, 1'b0, DIV, 32'd0, 32'd0, 1'b0);
        chk("fl_idle", busy_of(0), 64'd0);
        chk("fl_done", done_of(0), 64'd0);
        chk("fl_hilo", hilo(0), model(0));
        repeat (8) begin
            @(negedge clk);
            chk("fl_nodone", done_of(0), 64'd0);
        end

        // start together with flush is dropped, MTHI included.
        drive(0, 1'b1, MULT, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        chk("sf_busy", busy_of(0), 64'd0);
        chk("sf_hilo", hilo(0), model(0));
        drive(0, 1'b1, MTHI, 32'd123, 32'd0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, MTHI, 32'd0, 32'd0, 1'b0);
        chk("sf_mthi", hilo(0), model(0));

        // Retried start with new operands while busy is ignored.
        exp = ref_op(MULT, 32'd3, 32'd4, model(0));
        drive(0, 1'b1, MULT, 32'd3, 32'd4, 1'b0);
        for (int i = 1; i <= ml[0]; i++) begin
            @(negedge clk);
            chk("rb_busy", busy_of(0), 64'd1);
            if (i <= 2) drive(0, 1'b1, DIV, 32'd100, 32'd7, 1'b0);
            else        drive(0, 1'b0, DIV, 32'd0, 32'd0, 1'b0);
        end
        @(negedge clk);
        chk("rb_done", done_of(0), 64'd1);
        chk("rb_hilo", hilo(0), exp);
        {mhi[0], mlo[0]} = exp;

        // Reset in the middle of a multiply.
        run_op(1, MULTU, 32'hDEADBEEF, 32'h1234);
        drive(0, 1'b1, MULT, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, MULT, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk("mr_busy", busy_of(u), 64'd0);
            chk("mr_hilo", hilo(u), 64'd0);
            mhi[u] = '0;
            mlo[u] = '0;
        end
        @(negedge clk);
        chk("mr_done", done_of(0), 64'd0);

        // Latency limits on unit 1.
        run_op(1, MULT, 32'hFFFFFFFD, 32'd7);
        run_op(1, MADD, 32'd100, 32'hFFFFFFFF);
        run_op(1, DIV, 32'hFFFFFFF9, 32'd2);
        chk("l1_div", hilo(1), 64'hFFFFFFFF_FFFFFFFD);
        run_op(1, DIVU, 32'hFFFFFFFF, 32'd3);
        run_op(1, MSUBU, 32'd2, 32'd5);

        // Flush on the edge that would have completed a 1-cycle multiply.
        drive(1, 1'b1, MULT, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
        chk("fc_busy", busy_of(1), 64'd1);
        drive(1, 1'b0, MULT, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, MULT, 32'd0, 32'd0, 1'b0);
        chk("fc_idle", busy_of(1), 64'd0);
        chk("fc_done", done_of(1), 64'd0);
        chk("fc_hilo", hilo(1), model(1));

        // Randomised ops on both units, issued back-to-back.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 40; n++) begin
                sel = $urandom_range(0, 11);
                rop = (sel >= 10) ? 4'($urandom_range(10, 15)) : 4'(sel);
                ra  = $urandom;
                rb  = $urandom;
                case ($urandom_range(0, 7))
                    0: rb = 32'd0;
                    1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                    2: rb = 32'hFFFFFFFF;
                    3: rb = 32'($urandom_range(1, 15));
                    default: ;
                endcase
                run_op(u, rop, ra, rb);
            end
        end

        @(negedge clk);
        chk("end_done0", done_of(0), 64'd0);
        chk("end_done1", done_of(1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
